uart_rx_timing_gen: RTL
=======================

# uart_rx_timing_gen

Parametrised timing generator for the UART receiver: counts oversampling edges within a bit and bits within a frame, decodes a configurable frame format (5–8 data bits, optional parity, 1 or 2 stop bits), and emits three majority-vote sample strobes around each bit centre. It sits between the RX control FSM, which drives `enable`/`restart`, and the data sampler, deserializer, parity checker and stop checker, which consume the strobes and counts.

## Interface
- `PRESCALE_W`, 6, width of the prescale input and of `edge_cnt`; the legal prescale range is 4..2^PRESCALE_W-1.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: count while high; counters held at 0 while low.
- `restart` input 1: synchronous clear of both counters, used for start-edge resync.
- `prescale` input PRESCALE_W: oversampling ratio, in clk cycles per bit.
- `data_len` input 2: data bits = 5 + data_len.
- `par_en` input 1: the frame contains a parity bit.
- `stop2` input 1: the frame contains two stop bits.
- `edge_cnt` output PRESCALE_W: edge position within the current bit, 0..prescale-1.
- `bit_cnt` output 4: bit index within the frame; 0 is the start bit.
- `sample_stb` output 3: one-hot sample strobes at the bit centre -1, 0 and +1.
- `bit_done` output 1: last edge of the current bit.
- `frame_done` output 1: last edge of the last bit of the frame.
- `cfg_err` output 1: the latched prescale is below 4.

## Operation
- Configuration shadow: `prescale_q`, `len_q` and `mid_q` load every cycle in which `enable`=0.
  - `len_q` = N = 1 + (5+data_len) + par_en + (1+stop2), range 7..12.
  - `mid_q` = prescale >> 1.
- The shadow is frozen while `enable`=1, so mid-frame input changes have no effect until the next idle cycle.
- `cfg_err` = (`prescale_q` < 4), combinational from the shadow register.
- Counter update priority, highest first:
  - `enable`=0 → both counters 0.
  - `restart`=1 → both counters 0.
  - `cfg_err`=1 → both counters held at 0.
  - Otherwise count as below.
- Counting:
  - `edge_cnt` increments by 1 each cycle. At `prescale_q`-1 it wraps to 0 and `bit_cnt` increments.
  - When `bit_cnt`=N-1 and `edge_cnt`=`prescale_q`-1, both counters wrap to 0. This supports back-to-back frames with no idle cycle.
- Strobe decodes, all combinational from the registered counters and all gated by `enable` && !`cfg_err`:
  - `sample_stb[0]` when `edge_cnt`=`mid_q`-1.
  - `sample_stb[1]` when `edge_cnt`=`mid_q`.
  - `sample_stb[2]` when `edge_cnt`=`mid_q`+1.
  - `bit_done` when `edge_cnt`=`prescale_q`-1.
  - `frame_done` when `bit_done` && `bit_cnt`=`len_q`-1.
- Odd prescale: centre is the floor. For example, prescale=5 gives strobes at edges 1, 2 and 3.
- Width rules:
  - All compares are unsigned at PRESCALE_W bits.
  - prescale ≥ 4 guarantees `mid_q`-1 ≥ 1 and `mid_q`+1 ≤ prescale-1, so no compare under- or overflows.

## Timing
- Reset values:
  - `edge_cnt`=0, `bit_cnt`=0.
  - `prescale_q`=0, so `cfg_err`=1 until the first idle load.
  - `len_q`=7, `mid_q`=0.
  - `sample_stb`, `bit_done` and `frame_done` are 0 (gated by `cfg_err`).
- First cycle with `enable`=1: `edge_cnt` reads 0; it reads 1 on the following cycle.
- Strobes, `bit_done` and `frame_done` are single-cycle pulses, valid in the same cycle as the matching counter value (zero-latency decode).
- Bit period = `prescale_q` cycles. Frame period = N·`prescale_q` cycles, measured from the first enabled cycle to the end of the `frame_done` cycle.
- `enable` falling: counters read 0 on the next cycle and all pulses are suppressed immediately.
- `restart` coinciding with `bit_done`/`frame_done`: the pulse is still visible that cycle; counters go to 0, not to the wrap value.
- `rst_n` asserted mid-frame: all outputs take their reset values asynchronously.

## Test plan
- prescale=8, data_len=3, par_en=0, stop2=0 (8N1, N=10), `enable` held high → strobes at `edge_cnt` 3/4/5 in every bit; `bit_done` every 8th cycle; `frame_done` in cycle 80 with `bit_cnt`=9; cycle 81 shows `edge_cnt`=0, `bit_cnt`=0.
- prescale=16, data_len=2, par_en=1, stop2=1 (7E2, N=11) → strobes at 7/8/9; `frame_done` at cycle 176 with `bit_cnt`=10.
- prescale=5, 8N1 → strobes at 1/2/3; `bit_done` every 5 cycles; `frame_done` at cycle 50.
- With `enable` high at prescale=8, change prescale to 16 and data_len to 0 mid-frame → period stays 8 and N stays 10 until `enable` drops; the next frame uses 16 and N=7.
- prescale=3 loaded while idle, then `enable`=1 → `cfg_err`=1; counters stay 0 and no pulses occur. Load prescale=4 → strobes at edges 1/2/3.
- At `bit_cnt`=4, `edge_cnt`=6: pulse `restart` → counters 0 on the next cycle. Then drop `enable` → counters 0. Then assert `rst_n`=0 mid-count → all outputs reset asynchronously and `cfg_err`=1.

Source files
------------

// File: rtl/uart_rx_timing_gen.sv
// UART RX timing generator: edge/bit counters, frame-format decode and
// three majority-vote sample strobes around each bit centre.
module uart_rx_timing_gen #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_restart,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [1:0]            i_data_len,
    input  logic                  i_par_en,
    input  logic                  i_stop2,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [3:0]            o_bit_cnt,
    output logic [2:0]            o_sample_stb,
    output logic                  o_bit_done,
    output logic                  o_frame_done,
    output logic                  o_cfg_err
);

    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_mid;
    logic [3:0]            r_len;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [3:0]            r_bit_cnt;

    logic [PRESCALE_W-1:0] w_edge_d;
    logic [3:0]            w_bit_d;
    logic [3:0]            w_len;
    logic                  w_cfg_err;
    logic                  w_run;
    logic                  w_last_edge;
    logic                  w_last_bit;

    // start + data + parity + stop(s)
    assign w_len = 4'd7 + {2'b00, i_data_len} + {3'b000, i_par_en} + {3'b000, i_stop2};

    // Shadow tracks the inputs while idle and is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_mid      <= '0;
            r_len      <= 4'd7;
        end else if (!i_enable) begin
            r_prescale <= i_prescale;
            r_mid      <= i_prescale >> 1;
            r_len      <= w_len;
        end
    end

    assign w_cfg_err   = (r_prescale < PRESCALE_W'(4));
    assign w_run       = i_enable && !w_cfg_err;
    assign w_last_edge = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
    assign w_last_bit  = (r_bit_cnt == r_len - 4'd1);

    always_comb begin
        w_edge_d = '0;
        w_bit_d  = '0;
        if (w_run && !i_restart) begin
            if (w_last_edge) begin
                w_edge_d = '0;
                w_bit_d  = w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
            end else begin
                w_edge_d = r_edge_cnt + PRESCALE_W'(1);
                w_bit_d  = r_bit_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_edge_cnt <= w_edge_d;
            r_bit_cnt  <= w_bit_d;
        end
    end

    // prescale >= 4 keeps mid-1 and mid+1 inside 0..prescale-1
    assign o_sample_stb[0] = w_run && (r_edge_cnt == r_mid - PRESCALE_W'(1));
    assign o_sample_stb[1] = w_run && (r_edge_cnt == r_mid);
    assign o_sample_stb[2] = w_run && (r_edge_cnt == r_mid + PRESCALE_W'(1));
    assign o_bit_done      = w_run && w_last_edge;
    assign o_frame_done    = w_run && w_last_edge && w_last_bit;
    assign o_cfg_err       = w_cfg_err;
    assign o_edge_cnt      = r_edge_cnt;
    assign o_bit_cnt       = r_bit_cnt;

endmodule
